// File: rtl/alert_sequencer.sv
// Buzzer tone sequencer: Morse pass-through while armed, source-coded beep bursts on mistakes,
// solid tone while detonating. Optional low-time chirp is built only when WARN_CHIRP_EN is defined.
//
//   state      | meaning
//   IDLE       | bomb not armed, buzzer silent
//   MOS        | armed, buzzer follows Morse audio (plus chirp when enabled)
//   BURST_ON   | tone on for the current beep of a mistake burst
//   BURST_OFF  | silence after a beep; next beep or back to MOS
//   DETONATE   | solid tone until the central FSM leaves DETONATING
module alert_sequencer #(
  parameter int N_SRC          = 5,
  parameter int BEEP_ON_TICKS  = 15,
  parameter int BEEP_OFF_TICKS = 10,
  parameter int CHIRP_PERIOD   = 100,
  parameter int TICK_W         = 8,
  localparam int SRC_W         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_10ms,
  input  logic             mos_code_signal,
  input  logic [2:0]       current_state,
  input  logic [N_SRC-1:0] mistake_i,
  input  logic             time_low_i,
  output logic             bebe_o,
  output logic [2:0]       alert_state_o,
  output logic [SRC_W-1:0] src_o,
  output logic [7:0]       mistake_cnt_o
);

  localparam logic [2:0] GAME_ACTIVATED  = 3'b010;
  localparam logic [2:0] GAME_DETONATING = 3'b011;

  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(BEEP_ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(BEEP_OFF_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOS       = 3'd1,
    BURST_ON  = 3'd2,
    BURST_OFF = 3'd3,
    DETONATE  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic               bebe_n;
  logic [SRC_W-1:0]   src_n;
  logic [SRC_W-1:0]   beeps_left, beeps_n;
  logic [TICK_W-1:0]  tick_cnt, tick_n;
  logic [7:0]         cnt_n, cnt_inc;
  logic [N_SRC-1:0]   mistake_q;
  logic [N_SRC-1:0]   rise;
  logic               any_rise;
  logic [SRC_W-1:0]   winner;

`ifdef WARN_CHIRP_EN
  localparam logic [TICK_W-1:0] CHIRP_LAST = TICK_W'(CHIRP_PERIOD - 1);
  logic [TICK_W-1:0]  chirp_cnt, chirp_n;
`else
  logic               time_low_unused;
  assign time_low_unused = time_low_i;
`endif

  assign rise     = mistake_i & ~mistake_q;
  assign any_rise = |rise;
  assign cnt_inc  = (mistake_cnt_o == 8'hFF) ? 8'hFF : mistake_cnt_o + 8'd1;

  // Lowest set index wins when several sources rise together.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rise[i]) winner = SRC_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bebe_o        <= 1'b0;
      src_o         <= '0;
      beeps_left    <= '0;
      tick_cnt      <= '0;
      mistake_cnt_o <= 8'd0;
      mistake_q     <= '0;
`ifdef WARN_CHIRP_EN
      chirp_cnt     <= '0;
`endif
    end else begin
      state         <= state_n;
      bebe_o        <= bebe_n;
      src_o         <= src_n;
      beeps_left    <= beeps_n;
      tick_cnt      <= tick_n;
      mistake_cnt_o <= cnt_n;
      mistake_q     <= mistake_i;
`ifdef WARN_CHIRP_EN
      chirp_cnt     <= chirp_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    bebe_n  = 1'b0;
    src_n   = src_o;
    beeps_n = beeps_left;
    tick_n  = tick_cnt;
    cnt_n   = mistake_cnt_o;
`ifdef WARN_CHIRP_EN
    chirp_n = '0;
`endif
    if (current_state == GAME_DETONATING) begin
      state_n = DETONATE;
      bebe_n  = 1'b1;
      beeps_n = '0;
      tick_n  = '0;
    end else if (current_state != GAME_ACTIVATED) begin
      state_n = IDLE;
      beeps_n = '0;
      tick_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = MOS;
        MOS: begin
          bebe_n = mos_code_signal;
`ifdef WARN_CHIRP_EN
          if (time_low_i) begin
            bebe_n = mos_code_signal | (chirp_cnt == '0);
            if (tick_10ms)
              chirp_n = (chirp_cnt == CHIRP_LAST) ? '0 : chirp_cnt + TICK_W'(1);
            else
              chirp_n = chirp_cnt;
          end
`endif
        end
        BURST_ON: begin
          bebe_n = 1'b1;
          if (tick_10ms) begin
            if (tick_cnt == ON_LAST) begin
              state_n = BURST_OFF;
              tick_n  = '0;
            end else begin
              tick_n = tick_cnt + TICK_W'(1);
            end
          end
        end
        BURST_OFF: begin
          if (tick_10ms) begin
            if (tick_cnt == OFF_LAST) begin
              tick_n = '0;
              if (beeps_left == '0) begin
                state_n = MOS;
              end else begin
                beeps_n = beeps_left - SRC_W'(1);
                state_n = BURST_ON;
              end
            end else begin
              tick_n = tick_cnt + TICK_W'(1);
            end
          end
        end
        DETONATE: begin
          state_n = IDLE;
          beeps_n = '0;
          tick_n  = '0;
        end
        default: state_n = IDLE;
      endcase

      // A new mistake (re)starts a burst from any armed state; the newest event wins.
      if (any_rise && (state == MOS || state == BURST_ON || state == BURST_OFF)) begin
        state_n = BURST_ON;
        src_n   = winner;
        beeps_n = winner;
        tick_n  = '0;
        cnt_n   = cnt_inc;
      end
    end
  end

  assign alert_state_o = state;

endmodule

// File: tb/tb_alert_sequencer.sv
// Directed bench for alert_sequencer: reset, Morse pass-through, burst timing, retrigger,
// detonation, counter saturation, async reset mid-burst and the optional chirp.
module tb_alert_sequencer;

  logic       clk;
  logic       rst;
  logic       tick_10ms;
  logic       mos_code_signal;
  logic [2:0] current_state;
  logic [4:0] mistake_i;
  logic       time_low_i;
  logic       bebe_o;
  logic [2:0] alert_state_o;
  logic [2:0] src_o;
  logic [7:0] mistake_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  alert_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .tick_10ms      (tick_10ms),
    .mos_code_signal(mos_code_signal),
    .current_state  (current_state),
    .mistake_i      (mistake_i),
    .time_low_i     (time_low_i),
    .bebe_o         (bebe_o),
    .alert_state_o  (alert_state_o),
    .src_o          (src_o),
    .mistake_cnt_o  (mistake_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tick every 4 clocks; bebe_o sampled just before each tick.
  task automatic give_ticks(input int n, output int high);
    high = 0;
    for (int i = 0; i < n; i++) begin
      if (bebe_o) high++;
      tick_10ms = 1'b1;
      step(1);
      tick_10ms = 1'b0;
      step(3);
    end
  endtask

  task automatic run_burst(output int nt, output int high, output int rises);
    logic prev;
    prev  = 1'b0;
    nt    = 0;
    high  = 0;
    rises = 0;
    while (alert_state_o != 3'd1 && nt < 200) begin
      if (bebe_o) begin
        high++;
        if (!prev) rises++;
      end
      prev = bebe_o;
      tick_10ms = 1'b1;
      step(1);
      tick_10ms = 1'b0;
      step(3);
      nt++;
    end
  endtask

  initial begin
    int nt, high, rises;
    rst             = 1'b1;
    tick_10ms       = 1'b0;
    mos_code_signal = 1'b0;
    current_state   = 3'b000;
    mistake_i       = 5'b0;
    time_low_i      = 1'b0;

    // 1: reset
    step(3);
    rst = 1'b0;
    step(2);
    chk("reset_bebe", bebe_o, 0);
    chk("reset_state", alert_state_o, 0);
    chk("reset_cnt", mistake_cnt_o, 0);
    chk("reset_src", src_o, 0);

    // 2: Morse pass-through with one clock latency
    current_state = 3'b010;
    step(1);
    chk("mos_state", alert_state_o, 1);
    mos_code_signal = 1'b1; step(1); chk("mos_d1", bebe_o, 1);
    mos_code_signal = 1'b0; step(1); chk("mos_d2", bebe_o, 0);
    mos_code_signal = 1'b1; step(1); chk("mos_d3", bebe_o, 1);
    mos_code_signal = 1'b1; step(1); chk("mos_d4", bebe_o, 1);
    mos_code_signal = 1'b0; step(1); chk("mos_d5", bebe_o, 0);

    // 3: source 2 -> three beeps, 75 ticks
    mistake_i = 5'b00100;
    step(1);
    chk("b2_state", alert_state_o, 2);
    chk("b2_src", src_o, 2);
    chk("b2_cnt", mistake_cnt_o, 1);
    mistake_i = 5'b0;
    step(1);
    run_burst(nt, high, rises);
    chk("b2_ticks", nt, 75);
    chk("b2_high", high, 45);
    chk("b2_beeps", rises, 3);
    chk("b2_src_end", src_o, 2);
    chk("b2_cnt_end", mistake_cnt_o, 1);

    // 4: simultaneous rises [3],[1] -> source 1, two beeps
    mistake_i = 5'b01010;
    step(1);
    chk("b1_src", src_o, 1);
    chk("b1_cnt", mistake_cnt_o, 2);
    mistake_i = 5'b0;
    step(1);
    run_burst(nt, high, rises);
    chk("b1_ticks", nt, 50);
    chk("b1_high", high, 30);
    chk("b1_beeps", rises, 2);

    // 4b: retrigger in the first OFF phase with source 0
    mistake_i = 5'b01010;
    step(1);
    mistake_i = 5'b0;
    step(1);
    give_ticks(20, high);
    chk("rt_off_state", alert_state_o, 3);
    mistake_i = 5'b00001;
    step(1);
    chk("rt_state", alert_state_o, 2);
    chk("rt_src", src_o, 0);
    chk("rt_cnt", mistake_cnt_o, 4);
    mistake_i = 5'b0;
    step(1);
    run_burst(nt, high, rises);
    chk("rt_ticks", nt, 25);
    chk("rt_high", high, 15);
    chk("rt_beeps", rises, 1);

    // 5: detonation from a burst OFF phase
    mistake_i = 5'b10000;
    step(1);
    chk("b4_src", src_o, 4);
    mistake_i = 5'b0;
    step(1);
    give_ticks(17, high);
    chk("pre_det_bebe", bebe_o, 0);
    current_state = 3'b011;
    step(1);
    chk("det_bebe", bebe_o, 1);
    chk("det_state", alert_state_o, 4);
    mistake_i = 5'b00001;
    step(1);
    mistake_i = 5'b0;
    step(8);
    chk("det_hold", bebe_o, 1);
    chk("det_cnt_ignored", mistake_cnt_o, 5);
    current_state = 3'b000;
    step(1);
    chk("det_exit_bebe", bebe_o, 0);
    chk("det_exit_state", alert_state_o, 0);

    // 5b: counter saturation
    current_state = 3'b010;
    step(1);
    for (int i = 0; i < 250; i++) begin
      mistake_i = 5'b00001; step(1);
      mistake_i = 5'b0;     step(1);
    end
    chk("cnt_255", mistake_cnt_o, 255);
    mistake_i = 5'b00001; step(1);
    mistake_i = 5'b0;     step(1);
    chk("cnt_sat", mistake_cnt_o, 255);
    chk("sat_state", alert_state_o, 2);
    chk("sat_bebe", bebe_o, 1);

    // 5c: async reset mid-burst
    rst = 1'b1;
    #1;
    chk("arst_bebe", bebe_o, 0);
    chk("arst_state", alert_state_o, 0);
    chk("arst_cnt", mistake_cnt_o, 0);
    chk("arst_src", src_o, 0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("arst_mos", alert_state_o, 1);

    // 6: low-time chirp
    mos_code_signal = 1'b0;
    time_low_i      = 1'b1;
    step(1);
    give_ticks(250, high);
`ifdef WARN_CHIRP_EN
    chk("chirp_count", high, 3);
`else
    chk("chirp_count", high, 0);
`endif
    time_low_i = 1'b0;
    step(1);
    give_ticks(20, high);
    chk("chirp_off", high, 0);
    chk("chirp_state", alert_state_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
